// File: rtl/r88_pkg.sv
// r88_pkg
// Shared types and constants for the Rocket88 instruction-cycle sequencer.
//   r88_state_e     : sequencer state encoding
//   R88_VEC_*       : vector-select encodings driven on intVec
package r88_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_VEC    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4
  } r88_state_e;

  localparam int R88_VEC_RESET = 0;
  localparam int R88_VEC_NMI   = 1;
  localparam int R88_VEC_IRQ0  = 2;

endpackage

// File: rtl/r88_irq_arb.sv
// r88_irq_arb
// Interrupt arbiter: NMI rising-edge detector with pending flag, plus a
// lowest-index-wins priority encoder over the maskable IRQ lines.
// Ports:
//   sysClock, sysResetN : clock, async active-low reset
//   nmiReq              : raw NMI request (edge sensitive)
//   inRst               : sequencer is in RST; NMI edges are ignored there
//   nmiClr              : sequencer is entering VEC for the NMI this cycle
//   irq, irqEn          : level IRQs and global enable
//   take                : an interrupt would be taken at this boundary
//   isNmi               : the winning source is the NMI
//   vec                 : vector select of the winning source
module r88_irq_arb
  import r88_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = $clog2(NUM_IRQ + 2)
) (
  input  logic               sysClock,
  input  logic               sysResetN,
  input  logic               nmiReq,
  input  logic               inRst,
  input  logic               nmiClr,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irqEn,
  output logic               take,
  output logic               isNmi,
  output logic [VEC_W-1:0]   vec
);

  logic             nmiPrev_q;
  logic             nmiPend_q;
  logic             nmiPend_d;
  logic             nmiEdge;
  logic [VEC_W-1:0] irqIdx;

  assign nmiEdge = nmiReq & ~nmiPrev_q & ~inRst;

  // A fresh edge landing on the same clock as the clear must survive,
  // so the set term is ORed in after the clear is applied.
  assign nmiPend_d = nmiEdge | (nmiPend_q & ~nmiClr);

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      nmiPrev_q <= 1'b0;
      nmiPend_q <= 1'b0;
    end else begin
      nmiPrev_q <= nmiReq;
      nmiPend_q <= nmiPend_d;
    end
  end

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    irqIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) irqIdx = VEC_W'(i);
    end
  end

  assign isNmi = nmiPend_q;
  assign take  = nmiPend_q | (irqEn & (|irq));
  assign vec   = nmiPend_q ? VEC_W'(R88_VEC_NMI)
                           : VEC_W'(R88_VEC_IRQ0) + irqIdx;

endmodule

// File: rtl/r88_sequencer.sv
// r88_sequencer
// Instruction-cycle sequencer for the Rocket88 core. Walks
// RST -> VEC -> FETCH -> DECODE -> EXEC and arbitrates reset, NMI and
// NUM_IRQ prioritised IRQs at instruction boundaries.
// Optional feature: define R88_SEQ_WAIT_EN to add the memReady port and
// stall FETCH/EXEC on memory wait states.
// Ports:
//   sysClock, sysResetN : clock, async active-low reset
//   nmiReq              : NMI request, rising-edge sensitive
//   irq, irqEn          : level IRQs (bit 0 highest) and global enable
//   opcode              : instruction byte, captured when FETCH completes
//   instLen             : execute-cycle count from decode ROM (0 means 1)
//   memReady            : memory ready (R88_SEQ_WAIT_EN only)
//   fetch, incPC        : opcode read strobe, PC increment strobe
//   instReg             : latched opcode
//   cycle, execActive   : execute-cycle index, high in EXEC
//   instDone            : final execute cycle completing
//   intAck, intVec      : interrupt acknowledge pulse, vector select
module r88_sequencer
  import r88_pkg::*;
#(
  parameter int CYCLE_W = 3,
  parameter int DATA_W  = 8,
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = $clog2(NUM_IRQ + 2)
) (
  input  logic               sysClock,
  input  logic               sysResetN,
  input  logic               nmiReq,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irqEn,
  input  logic [DATA_W-1:0]  opcode,
  input  logic [CYCLE_W-1:0] instLen,
`ifdef R88_SEQ_WAIT_EN
  input  logic               memReady,
`endif
  output logic               fetch,
  output logic               incPC,
  output logic [DATA_W-1:0]  instReg,
  output logic [CYCLE_W-1:0] cycle,
  output logic               execActive,
  output logic               instDone,
  output logic               intAck,
  output logic [VEC_W-1:0]   intVec
);

  r88_state_e         state_q;
  logic               vSub_q;
  logic [CYCLE_W-1:0] len_q;
  logic [CYCLE_W-1:0] cycle_q;
  logic [DATA_W-1:0]  instReg_q;
  logic [VEC_W-1:0]   intVec_q;
  logic               ack_q;

  logic               cmpl;
  logic               lastCyc;
  logic               boundary;
  logic               take;
  logic               isNmi;
  logic [VEC_W-1:0]   arbVec;
  logic               nmiClr;
  logic [CYCLE_W-1:0] lenEff;

`ifdef R88_SEQ_WAIT_EN
  assign cmpl = memReady;
`else
  assign cmpl = 1'b1;
`endif

  assign lenEff   = (instLen == '0) ? CYCLE_W'(1) : instLen;
  assign lastCyc  = (cycle_q == (len_q - CYCLE_W'(1)));
  assign boundary = (state_q == ST_EXEC) && lastCyc && cmpl;
  assign nmiClr   = boundary && take && isNmi;

  r88_irq_arb #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_arb (
    .sysClock  (sysClock),
    .sysResetN (sysResetN),
    .nmiReq    (nmiReq),
    .inRst     (state_q == ST_RST),
    .nmiClr    (nmiClr),
    .irq       (irq),
    .irqEn     (irqEn),
    .take      (take),
    .isNmi     (isNmi),
    .vec       (arbVec)
  );

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state_q   <= ST_RST;
      vSub_q    <= 1'b0;
      len_q     <= CYCLE_W'(1);
      cycle_q   <= '0;
      instReg_q <= '0;
      intVec_q  <= VEC_W'(R88_VEC_RESET);
      ack_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          // Reset vector: no acknowledge pulse.
          state_q  <= ST_VEC;
          vSub_q   <= 1'b0;
          intVec_q <= VEC_W'(R88_VEC_RESET);
          ack_q    <= 1'b0;
        end
        ST_VEC: begin
          ack_q <= 1'b0;
          if (!vSub_q) vSub_q  <= 1'b1;
          else         state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (cmpl) begin
            instReg_q <= opcode;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          len_q   <= lenEff;
          cycle_q <= '0;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cmpl) begin
            if (lastCyc) begin
              if (take) begin
                state_q  <= ST_VEC;
                vSub_q   <= 1'b0;
                intVec_q <= arbVec;
                ack_q    <= 1'b1;
              end else begin
                state_q <= ST_FETCH;
              end
            end else begin
              cycle_q <= cycle_q + CYCLE_W'(1);
            end
          end
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign fetch      = (state_q == ST_FETCH);
  assign incPC      = (state_q == ST_DECODE);
  assign execActive = (state_q == ST_EXEC);
  assign instDone   = boundary;
  assign intAck     = ack_q;
  assign intVec     = intVec_q;
  assign instReg    = instReg_q;
  assign cycle      = cycle_q;

endmodule

// File: tb/tb_r88_sequencer.sv
module tb_r88_sequencer;
  import r88_pkg::*;

  logic       sysClock;
  logic       sysResetN;
  logic       nmiReq;
  logic [3:0] irq;
  logic       irqEn;
  logic [7:0] opcode;
  logic [2:0] instLen;
`ifdef R88_SEQ_WAIT_EN
  logic       memReady;
`endif
  logic       fetch, incPC, execActive, instDone, intAck;
  logic [7:0] instReg;
  logic [2:0] cycle;
  logic [2:0] intVec;
  logic [4:0] strb;

  int checks;
  int failures;

  r88_sequencer dut (
    .sysClock   (sysClock),
    .sysResetN  (sysResetN),
    .nmiReq     (nmiReq),
    .irq        (irq),
    .irqEn      (irqEn),
    .opcode     (opcode),
    .instLen    (instLen),
`ifdef R88_SEQ_WAIT_EN
    .memReady   (memReady),
`endif
    .fetch      (fetch),
    .incPC      (incPC),
    .instReg    (instReg),
    .cycle      (cycle),
    .execActive (execActive),
    .instDone   (instDone),
    .intAck     (intAck),
    .intVec     (intVec)
  );

  // {fetch, incPC, execActive, instDone, intAck}
  assign strb = {fetch, incPC, execActive, instDone, intAck};

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysClock);
      #1;
    end
  endtask

  task automatic test_reset;
    sysResetN = 1'b0; nmiReq = 1'b0; irq = 4'h0; irqEn = 1'b0;
    opcode = 8'h00; instLen = 3'd3;
`ifdef R88_SEQ_WAIT_EN
    memReady = 1'b1;
`endif
    tick(2);
    checks++; if (strb !== 5'b00000) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", strb, 5'b00000); end
    checks++; if (instReg !== 8'h00) begin failures++; $display("FAIL reset_instReg got=%h exp=%h", instReg, 8'h00); end
    checks++; if (cycle !== 3'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=%0d", cycle, 0); end
    checks++; if (intVec !== 3'd0) begin failures++; $display("FAIL reset_intVec got=%0d exp=%0d", intVec, 0); end
  endtask

  // Reset release, instLen=3: fetch at clock 3, incPC at 4, done at 7, fetch at 8.
  task automatic test_basic;
    opcode = 8'hA5; instLen = 3'd3;
    sysResetN = 1'b1;
    tick(1);
    checks++; if (strb !== 5'b00000) begin failures++; $display("FAIL basic_vec0 got=%b exp=%b", strb, 5'b00000); end
    checks++; if (intVec !== 3'd0) begin failures++; $display("FAIL basic_vec0_intVec got=%0d exp=%0d", intVec, 0); end
    tick(1);
    checks++; if (strb !== 5'b00000) begin failures++; $display("FAIL basic_vec1 got=%b exp=%b", strb, 5'b00000); end
    tick(1);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL basic_fetch_clk3 got=%b exp=%b", strb, 5'b10000); end
    tick(1);
    checks++; if (strb !== 5'b01000) begin failures++; $display("FAIL basic_incpc_clk4 got=%b exp=%b", strb, 5'b01000); end
    checks++; if (instReg !== 8'hA5) begin failures++; $display("FAIL basic_instReg got=%h exp=%h", instReg, 8'hA5); end
    tick(1);
    checks++; if (strb !== 5'b00100 || cycle !== 3'd0) begin failures++; $display("FAIL basic_exec0 got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00100, 0); end
    tick(1);
    checks++; if (strb !== 5'b00100 || cycle !== 3'd1) begin failures++; $display("FAIL basic_exec1 got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00100, 1); end
    tick(1);
    checks++; if (strb !== 5'b00110 || cycle !== 3'd2) begin failures++; $display("FAIL basic_done_clk7 got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00110, 2); end
    tick(1);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL basic_fetch_clk8 got=%b exp=%b", strb, 5'b10000); end
  endtask

  // Starts in FETCH. irq=1010 -> vector 3; after one instruction irq=1000 -> vector 5.
  task automatic test_irq;
    irq = 4'b1010; irqEn = 1'b1; instLen = 3'd2; opcode = 8'h11;
    tick(1);
    checks++; if (instReg !== 8'h11) begin failures++; $display("FAIL irq_instReg got=%h exp=%h", instReg, 8'h11); end
    tick(2);
    checks++; if (strb !== 5'b00110) begin failures++; $display("FAIL irq_boundary got=%b exp=%b", strb, 5'b00110); end
    tick(1);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd3) begin failures++; $display("FAIL irq_vec3_entry got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 3); end
    irq = 4'b1000;
    tick(1);
    checks++; if (strb !== 5'b00000) begin failures++; $display("FAIL irq_ack_oneshot got=%b exp=%b", strb, 5'b00000); end
    tick(1);
    checks++; if (strb !== 5'b10000 || intVec !== 3'd3) begin failures++; $display("FAIL irq_no_b2b got=%b/%0d exp=%b/%0d", strb, intVec, 5'b10000, 3); end
    tick(3);
    checks++; if (strb !== 5'b00110) begin failures++; $display("FAIL irq_boundary2 got=%b exp=%b", strb, 5'b00110); end
    tick(1);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd5) begin failures++; $display("FAIL irq_vec5_entry got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 5); end
    tick(2);
    irq = 4'h0; irqEn = 1'b0;
  endtask

  // Starts in FETCH. NMI edge + irq[0] -> vector 1 then vector 2; then a
  // second NMI edge during the NMI VEC is latched and taken next boundary.
  task automatic test_nmi;
    irq = 4'b0001; irqEn = 1'b1; instLen = 3'd2;
    tick(1);
    nmiReq = 1'b1;
    tick(1);
    nmiReq = 1'b0;
    tick(2);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd1) begin failures++; $display("FAIL nmi_first got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 1); end
    tick(2);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL nmi_then_fetch got=%b exp=%b", strb, 5'b10000); end
    tick(4);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd2) begin failures++; $display("FAIL nmi_irq0_after got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 2); end
    irq = 4'h0;
    tick(2);
    nmiReq = 1'b1;
    tick(1);
    nmiReq = 1'b0;
    tick(3);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd1) begin failures++; $display("FAIL nmi_second_entry got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 1); end
    nmiReq = 1'b1;
    tick(1);
    nmiReq = 1'b0;
    tick(5);
    checks++; if (strb !== 5'b00001 || intVec !== 3'd1) begin failures++; $display("FAIL nmi_latched_in_vec got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00001, 1); end
    tick(2);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL nmi_no_extra got=%b exp=%b", strb, 5'b10000); end
    irqEn = 1'b0;
  endtask

  // Starts in FETCH. Masked IRQs, instLen=0 executes one cycle.
  task automatic test_masked_len0;
    irq = 4'hF; irqEn = 1'b0; instLen = 3'd0;
    tick(2);
    checks++; if (strb !== 5'b00110 || cycle !== 3'd0) begin failures++; $display("FAIL len0_single got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00110, 0); end
    tick(1);
    checks++; if (strb !== 5'b10000 || intVec !== 3'd1) begin failures++; $display("FAIL masked_no_vec got=%b/%0d exp=%b/%0d", strb, intVec, 5'b10000, 1); end
    irq = 4'h0;
  endtask

`ifdef R88_SEQ_WAIT_EN
  // Starts in FETCH. 2 FETCH waits + 1 EXEC wait stretch by 3 clocks.
  task automatic test_wait;
    instLen = 3'd2; memReady = 1'b0;
    tick(1);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL wait_fetch_hold1 got=%b exp=%b", strb, 5'b10000); end
    tick(1);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL wait_fetch_hold2 got=%b exp=%b", strb, 5'b10000); end
    memReady = 1'b1;
    tick(1);
    checks++; if (strb !== 5'b01000) begin failures++; $display("FAIL wait_decode got=%b exp=%b", strb, 5'b01000); end
    tick(2);
    checks++; if (strb !== 5'b00110 || cycle !== 3'd1) begin failures++; $display("FAIL wait_last got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00110, 1); end
    memReady = 1'b0; #1;
    checks++; if (strb !== 5'b00100) begin failures++; $display("FAIL wait_done_gated got=%b exp=%b", strb, 5'b00100); end
    tick(1);
    checks++; if (strb !== 5'b00100 || cycle !== 3'd1) begin failures++; $display("FAIL wait_exec_hold got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00100, 1); end
    memReady = 1'b1; #1;
    checks++; if (strb !== 5'b00110) begin failures++; $display("FAIL wait_done_once got=%b exp=%b", strb, 5'b00110); end
    tick(1);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL wait_next_fetch got=%b exp=%b", strb, 5'b10000); end
  endtask
`endif

  // Starts in FETCH. Reset mid-EXEC with NMI pending clears everything.
  task automatic test_reset_mid;
    instLen = 3'd3; irq = 4'h0; irqEn = 1'b0; opcode = 8'h5A;
    tick(1);
    nmiReq = 1'b1;
    tick(1);
    nmiReq = 1'b0;
    tick(1);
    checks++; if (strb !== 5'b00100 || cycle !== 3'd1) begin failures++; $display("FAIL rmid_pre got=%b/%0d exp=%b/%0d", strb, cycle, 5'b00100, 1); end
    sysResetN = 1'b0; #1;
    checks++; if (strb !== 5'b00000 || cycle !== 3'd0 || intVec !== 3'd0 || instReg !== 8'h00) begin failures++; $display("FAIL rmid_async got=%b/%0d/%0d/%h exp=00000/0/0/00", strb, cycle, intVec, instReg); end
    tick(2);
    sysResetN = 1'b1;
    tick(1);
    checks++; if (strb !== 5'b00000 || intVec !== 3'd0) begin failures++; $display("FAIL rmid_resetvec got=%b/%0d exp=%b/%0d", strb, intVec, 5'b00000, 0); end
    tick(2);
    checks++; if (strb !== 5'b10000) begin failures++; $display("FAIL rmid_fetch got=%b exp=%b", strb, 5'b10000); end
    tick(4);
    checks++; if (strb !== 5'b00110) begin failures++; $display("FAIL rmid_done got=%b exp=%b", strb, 5'b00110); end
    tick(1);
    checks++; if (strb !== 5'b10000 || intVec !== 3'd0) begin failures++; $display("FAIL rmid_pend_cleared got=%b/%0d exp=%b/%0d", strb, intVec, 5'b10000, 0); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_irq();
    test_nmi();
    test_masked_len0();
`ifdef R88_SEQ_WAIT_EN
    test_wait();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
